// File: rtl/upc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : upc_pkg
//  Description : Shared types and default widths for the up-counter timer
//                controller (state encoding, default count/prescale widths).
//  Revision    : 1.0 - initial release
// ============================================================================
package upc_pkg;

    // Controller states; encoding is fixed so software/debug views stay stable.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } upc_state_t;

    localparam int UPC_CNT_W = 32;
    localparam int UPC_PRE_W = 8;

endpackage : upc_pkg
`default_nettype wire

// File: rtl/upc_prescaler.sv
`default_nettype none
// ============================================================================
//  Module      : upc_prescaler
//  Description : Step divider. While enabled, counts 0..div and raises a
//                step strobe on the cycle the internal count equals div,
//                wrapping back to 0 on that edge. Holds while disabled.
//  Ports       : clk  - clock (posedge)
//                rst  - synchronous active-high reset
//                clr  - synchronous clear of the divider count (beats en)
//                en   - advance the divider this cycle
//                div  - divide value; a step every (div+1) enabled cycles
//                step - strobe, valid in the cycle the edge will step
//  Revision    : 1.0 - initial release
// ============================================================================
module upc_prescaler #(
    parameter int PRE_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [PRE_W-1:0] div,
    output logic             step
);

    logic [PRE_W-1:0] cnt_q;
    logic [PRE_W-1:0] cnt_d;

    // Strobe is combinational so the owning FSM acts on the same edge
    // that wraps the divider.
    assign step = en && (cnt_q == div);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            if (step) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : upc_prescaler
`default_nettype wire

// File: rtl/upc_timer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : upc_timer_ctrl
//  Description : Programmable timer controller. Sequences an up-counter from
//                0 to a captured period at a prescaled rate, pulses tc on
//                each terminal-count step, and either reloads or parks in
//                DONE. Configuration is shadowed at start so mid-run input
//                changes have no effect.
//  Ports       : clk, rst        - clock / synchronous active-high reset
//                start           - begin a run (honoured in IDLE and DONE)
//                pause           - level; freeze counting while in RUN
//                abort           - level; return to IDLE from any state
//                auto_reload     - wrap at terminal count (captured at start)
//                period          - terminal count value (captured at start)
//                prescale        - step divider (captured at start)
//                count           - current count
//                busy / paused   - RUN or PAUSE / PAUSE
//                tc              - one-cycle terminal-count pulse
//                done            - one-shot run complete (DONE state)
//                cfg_err         - one-cycle pulse on a rejected start
//  Revision    : 1.0 - initial release
// ============================================================================
module upc_timer_ctrl
    import upc_pkg::*;
#(
    parameter int CNT_W = UPC_CNT_W,
    parameter int PRE_W = UPC_PRE_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             pause,
    input  logic             abort,
    input  logic             auto_reload,
    input  logic [CNT_W-1:0] period,
    input  logic [PRE_W-1:0] prescale,
    output logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             paused,
    output logic             tc,
    output logic             done,
    output logic             cfg_err
);

    upc_state_t       state_q,    state_d;
    logic [CNT_W-1:0] count_q,    count_d;
    logic [CNT_W-1:0] period_q,   period_d;
    logic [PRE_W-1:0] prescale_q, prescale_d;
    logic             auto_q,     auto_d;
    logic             tc_q,       tc_d;
    logic             cfg_err_q,  cfg_err_d;

    logic w_can_start;
    logic w_start_ok;
    logic w_pre_clr;
    logic w_pre_en;
    logic w_step;

    // Prescaler controls are derived outside the FSM process so the step
    // strobe it returns never feeds back into its own enable/clear.
    assign w_can_start = (state_q == IDLE) || (state_q == DONE);
    assign w_start_ok  = !abort && w_can_start && start && (period != '0);
    assign w_pre_clr   = abort || w_start_ok;
    assign w_pre_en    = !abort && !pause && (state_q == RUN);

    upc_prescaler #(
        .PRE_W (PRE_W)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_pre_clr),
        .en   (w_pre_en),
        .div  (prescale_q),
        .step (w_step)
    );

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        period_d   = period_q;
        prescale_d = prescale_q;
        auto_d     = auto_q;
        tc_d       = 1'b0;
        cfg_err_d  = 1'b0;

        if (abort) begin
            // Abort wins over pause/start/step, so tc is never raised here.
            state_d = IDLE;
            count_d = '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        if (period == '0) begin
                            cfg_err_d = 1'b1;
                        end else begin
                            period_d   = period;
                            prescale_d = prescale;
                            auto_d     = auto_reload;
                            count_d    = '0;
                            state_d    = RUN;
                        end
                    end
                end
                RUN: begin
                    if (pause) begin
                        state_d = PAUSE;
                    end else if (w_step) begin
                        if (count_q == period_q) begin
                            tc_d = 1'b1;
                            if (auto_q) begin
                                count_d = '0;
                            end else begin
                                // One-shot: count parks at period_q in DONE.
                                state_d = DONE;
                            end
                        end else begin
                            count_d = count_q + 1'b1;
                        end
                    end
                end
                PAUSE: begin
                    if (!pause) begin
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            count_q    <= '0;
            period_q   <= '0;
            prescale_q <= '0;
            auto_q     <= 1'b0;
            tc_q       <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            period_q   <= period_d;
            prescale_q <= prescale_d;
            auto_q     <= auto_d;
            tc_q       <= tc_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

    // Status flags are pure decodes of the state register.
    assign count   = count_q;
    assign busy    = (state_q == RUN) || (state_q == PAUSE);
    assign paused  = (state_q == PAUSE);
    assign done    = (state_q == DONE);
    assign tc      = tc_q;
    assign cfg_err = cfg_err_q;

endmodule : upc_timer_ctrl
`default_nettype wire

// File: tb/tb_upc_timer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_upc_timer_ctrl
//  Description : Self-checking bench for upc_timer_ctrl. Directed scenarios
//                plus a randomized run against an elapsed-cycle model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_upc_timer_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        pause = 1'b0;
    logic        abort = 1'b0;
    logic        auto_reload = 1'b0;
    logic [31:0] period = '0;
    logic [7:0]  prescale = '0;
    logic [31:0] count;
    logic        busy, paused, tc, done, cfg_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [36:0] exp;

    upc_timer_ctrl #(.CNT_W(32), .PRE_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .pause       (pause),
        .abort       (abort),
        .auto_reload (auto_reload),
        .period      (period),
        .prescale    (prescale),
        .count       (count),
        .busy        (busy),
        .paused      (paused),
        .tc          (tc),
        .done        (done),
        .cfg_err     (cfg_err)
    );

    always #5 clk = ~clk;

    // Packed view {count, busy, paused, tc, done, cfg_err}.
    function automatic logic [36:0] outs();
        return {count, busy, paused, tc, done, cfg_err};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1; start = 1'b0; pause = 1'b0; abort = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; period = 32'd5; auto_reload = 1'b1;
        tick(); tick();
        exp = {32'd0, 5'b00000}; n_checks++;
        if (outs() !== exp) begin n_fail++; $display("FAIL reset_state: got %h want %h", outs(), exp); end
        rst = 1'b0; start = 1'b0;
        tick();
        exp = {32'd0, 5'b00000}; n_checks++;
        if (outs() !== exp) begin n_fail++; $display("FAIL reset_idle_hold: got %h want %h", outs(), exp); end
    endtask

    task automatic test_one_shot();
        apply_reset();
        period = 32'd3; prescale = 8'd0; auto_reload = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            exp = {k[31:0], 5'b10000}; n_checks++;
            if (outs() !== exp) begin n_fail++; $display("FAIL one_shot_count%0d: got %h want %h", k, outs(), exp); end
            tick();
        end
        exp = {32'd3, 5'b00110}; n_checks++;
        if (outs() !== exp) begin n_fail++; $display("FAIL one_shot_tc: got %h want %h", outs(), exp); end
        tick();
        exp = {32'd3, 5'b00010}; n_checks++;
        if (outs() !== exp) begin n_fail++; $display("FAIL one_shot_done_hold: got %h want %h", outs(), exp); end
    endtask

    task automatic test_auto_reload();
        apply_reset();
        period = 32'd1; prescale = 8'd2; auto_reload = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        exp = {32'd0, 5'b10000}; n_checks++;
        if (outs() !== exp) begin n_fail++; $display("FAIL auto_start: got %h want %h", outs(), exp); end
        for (int k = 1; k <= 18; k++) begin
            tick();
            exp = {32'((k / 3) % 2), 1'b1, 1'b0, ((k % 6) == 0), 1'b0, 1'b0}; n_checks++;
            if (outs() !== exp) begin n_fail++; $display("FAIL auto_reload_k%0d: got %h want %h", k, outs(), exp); end
        end
    endtask

    task automatic test_pause_abort();
        apply_reset();
        period = 32'd5; prescale = 8'd0; auto_reload = 1'b0; start = 1'b1;
        tick(); start = 1'b0;
        tick(); tick();
        exp = {32'd2, 5'b10000}; n_checks++;
        if (outs() !== exp) begin n_fail++; $display("FAIL pause_pre: got %h want %h", outs(), exp); end
        pause = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            exp = {32'd2, 5'b11000}; n_checks++;
            if (outs() !== exp) begin n_fail++; $display("FAIL paused_c%0d: got %h want %h", k, outs(), exp); end
        end
        pause = 1'b0;
        tick();
        exp = {32'd2, 5'b10000}; n_checks++;
        if (outs() !== exp) begin n_fail++; $display("FAIL resume_edge: got %h want %h", outs(), exp); end
        tick();
        exp = {32'd3, 5'b10000}; n_checks++;
        if (outs() !== exp) begin n_fail++; $display("FAIL resume_step: got %h want %h", outs(), exp); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        exp = {32'd0, 5'b00000}; n_checks++;
        if (outs() !== exp) begin n_fail++; $display("FAIL abort_run: got %h want %h", outs(), exp); end
    endtask

    task automatic test_cfg_err();
        apply_reset();
        period = 32'd0; prescale = 8'd1; start = 1'b1;
        tick();
        start = 1'b0;
        exp = {32'd0, 5'b00001}; n_checks++;
        if (outs() !== exp) begin n_fail++; $display("FAIL cfg_err_pulse: got %h want %h", outs(), exp); end
        tick();
        exp = {32'd0, 5'b00000}; n_checks++;
        if (outs() !== exp) begin n_fail++; $display("FAIL cfg_err_clear: got %h want %h", outs(), exp); end
    endtask

    task automatic test_abort_priority();
        apply_reset();
        period = 32'd2; prescale = 8'd0; auto_reload = 1'b0; start = 1'b1;
        tick(); start = 1'b0;
        tick(); tick();
        exp = {32'd2, 5'b10000}; n_checks++;
        if (outs() !== exp) begin n_fail++; $display("FAIL prio_pre: got %h want %h", outs(), exp); end
        // Next edge would be the terminal-count step.
        abort = 1'b1; pause = 1'b1;
        tick();
        abort = 1'b0; pause = 1'b0;
        exp = {32'd0, 5'b00000}; n_checks++;
        if (outs() !== exp) begin n_fail++; $display("FAIL abort_pause_tc: got %h want %h", outs(), exp); end
        tick();
        exp = {32'd0, 5'b00000}; n_checks++;
        if (outs() !== exp) begin n_fail++; $display("FAIL abort_no_late_tc: got %h want %h", outs(), exp); end
    endtask

    task automatic test_rst_mid_run();
        apply_reset();
        period = 32'd4; prescale = 8'd1; auto_reload = 1'b1; start = 1'b1;
        tick(); start = 1'b0;
        tick(); tick(); tick();
        exp = {32'd1, 5'b10000}; n_checks++;
        if (outs() !== exp) begin n_fail++; $display("FAIL rst_mid_pre: got %h want %h", outs(), exp); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp = {32'd0, 5'b00000}; n_checks++;
        if (outs() !== exp) begin n_fail++; $display("FAIL rst_mid_run: got %h want %h", outs(), exp); end
    endtask

    task automatic test_shadow_regs();
        apply_reset();
        period = 32'd2; prescale = 8'd1; auto_reload = 1'b0; start = 1'b1;
        tick();
        start = 1'b0; period = 32'd7; prescale = 8'd3; auto_reload = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            exp = {32'(k / 2), 5'b10000}; n_checks++;
            if (outs() !== exp) begin n_fail++; $display("FAIL shadow_k%0d: got %h want %h", k, outs(), exp); end
        end
        tick();
        exp = {32'd2, 5'b00110}; n_checks++;
        if (outs() !== exp) begin n_fail++; $display("FAIL shadow_tc: got %h want %h", outs(), exp); end
        period = 32'd1; prescale = 8'd0; auto_reload = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        exp = {32'd0, 5'b10000}; n_checks++;
        if (outs() !== exp) begin n_fail++; $display("FAIL restart_from_done: got %h want %h", outs(), exp); end
        tick();
        exp = {32'd1, 5'b10000}; n_checks++;
        if (outs() !== exp) begin n_fail++; $display("FAIL restart_step: got %h want %h", outs(), exp); end
        tick();
        exp = {32'd1, 5'b00110}; n_checks++;
        if (outs() !== exp) begin n_fail++; $display("FAIL restart_tc: got %h want %h", outs(), exp); end
    endtask

    // Model: a run is a sequence of n un-paused RUN cycles; the terminal
    // step lands when n reaches (period+1)*(prescale+1), and between steps
    // the count is simply n / (prescale+1).
    task automatic test_random();
        bit          active = 1'b0, frozen = 1'b0, finished = 1'b0;
        longint      n = 0, len;
        longint      s_per = 0, s_pre = 0;
        bit          s_auto = 1'b0;
        logic [31:0] e_cnt = '0;
        bit          e_tc, e_cfg;
        apply_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst   = ($urandom_range(0, 299) == 0);
            abort = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 7) == 0) pause = ~pause;
            start       = !pause && ($urandom_range(0, 5) == 0);
            period      = 32'($urandom_range(0, 4));
            prescale    = 8'($urandom_range(0, 3));
            auto_reload = 1'($urandom_range(0, 1));
            e_tc = 1'b0; e_cfg = 1'b0;
            if (rst) begin
                active = 0; frozen = 0; finished = 0; n = 0; e_cnt = '0;
                s_per = 0; s_pre = 0; s_auto = 0;
            end else if (abort) begin
                active = 0; frozen = 0; finished = 0; n = 0; e_cnt = '0;
            end else if (active && !frozen) begin
                if (pause) begin
                    frozen = 1;
                end else begin
                    n++;
                    len = (s_per + 1) * (s_pre + 1);
                    if (n == len) begin
                        e_tc = 1'b1;
                        n = 0;
                        if (s_auto) e_cnt = '0;
                        else begin active = 0; finished = 1; e_cnt = 32'(s_per); end
                    end else begin
                        e_cnt = 32'(n / (s_pre + 1));
                    end
                end
            end else if (active && frozen) begin
                if (!pause) frozen = 0;
            end else if (start) begin
                if (period == 0) e_cfg = 1'b1;
                else begin
                    s_per = longint'(period); s_pre = longint'(prescale); s_auto = auto_reload;
                    active = 1; finished = 0; n = 0; e_cnt = '0;
                end
            end
            tick();
            exp = {e_cnt, active, frozen, e_tc, finished, e_cfg}; n_checks++;
            if (outs() !== exp) begin
                n_fail++;
                $display("FAIL random_cyc%0d: got %h want %h", cyc, outs(), exp);
            end
        end
        rst = 1'b0; abort = 1'b0; pause = 1'b0; start = 1'b0;
    endtask

    initial begin
        test_reset();
        test_one_shot();
        test_auto_reload();
        test_pause_abort();
        test_cfg_err();
        test_abort_priority();
        test_rst_mid_run();
        test_shadow_regs();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule : tb_upc_timer_ctrl
`default_nettype wire
